// File: rtl/bht_predict_unit.sv
// Prediction front end of a 2-bit saturating-counter branch history table.
// Lookups read a counter and queue {index, counter}; in-order resolves pop, update and flag mispredicts.
module bht_predict_unit #(
  parameter int          PC_WIDTH   = 32,
  parameter int          INDEX_BITS = 6,
  parameter int          QDEPTH     = 4,
  parameter logic [1:0]  INIT_STATE = 2'd1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_req,
  input  logic [PC_WIDTH-1:0]        pred_pc,
  output logic                       pred_ready,
  output logic                       pred_valid,
  output logic                       pred_taken,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic                       flush,
  output logic                       mispredict,
  output logic                       res_err,
  output logic [$clog2(QDEPTH):0]    inflight
);

  localparam int PTR     = $clog2(QDEPTH);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [PTR:0] DEPTH_CNT = (PTR+1)'(QDEPTH);

  logic [1:0]            bht   [ENTRIES];
  logic [INDEX_BITS-1:0] q_idx [QDEPTH];
  logic [1:0]            q_ctr [QDEPTH];

  logic [PTR-1:0]        head;
  logic [PTR-1:0]        tail;
  logic [PTR:0]          count;

  logic [INDEX_BITS-1:0] lookup_idx;
  logic [1:0]            lookup_ctr;
  logic [INDEX_BITS-1:0] head_idx;
  logic [1:0]            head_ctr;
  logic [1:0]            next_ctr;
  logic                  accept;
  logic                  pop;
  logic                  unused_pc;

  assign unused_pc  = ^{pred_pc[PC_WIDTH-1:INDEX_BITS+2], pred_pc[1:0]};
  assign lookup_idx = pred_pc[INDEX_BITS+1:2];
  assign lookup_ctr = bht[lookup_idx];
  assign head_idx   = q_idx[head];
  assign head_ctr   = q_ctr[head];

  // Readiness depends only on the registered occupancy, so a same-cycle pop never frees a slot early.
  assign pred_ready = (count < DEPTH_CNT);
  assign accept     = pred_req && pred_ready;
  assign pop        = res_valid && (count != '0);
  assign inflight   = count;

  always_comb begin
    next_ctr = head_ctr;
    unique case (head_ctr)
      2'd0:    next_ctr = res_taken ? 2'd1 : 2'd0;
      2'd1:    next_ctr = res_taken ? 2'd2 : 2'd0;
      2'd2:    next_ctr = res_taken ? 2'd3 : 2'd1;
      default: next_ctr = res_taken ? 2'd3 : 2'd2;
    endcase
  end

  // The table write is non-blocking, so a same-cycle lookup of the same index sees the old counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= INIT_STATE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      mispredict <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      pred_valid <= accept && !flush;
      if (accept && !flush) pred_taken <= lookup_ctr[1];
      mispredict <= pop && (head_ctr[1] != res_taken);
      res_err    <= res_valid && (count == '0);

      if (pop) bht[head_idx] <= next_ctr;

      if (accept) begin
        q_idx[tail] <= lookup_idx;
        q_ctr[tail] <= lookup_ctr;
      end

      // Flush drops whatever survives the resolve, including a push made this very cycle.
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (pop)    head <= head + PTR'(1);
        if (accept) tail <= tail + PTR'(1);
        count <= count + (PTR+1)'(accept) - (PTR+1)'(pop);
      end
    end
  end

endmodule

// File: tb/tb_bht_predict_unit.sv
// Self-checking bench for bht_predict_unit: directed scenarios plus a random phase,
// compared against a queue-and-array model of the counter table.
module tb_bht_predict_unit;

  localparam int PC_WIDTH   = 32;
  localparam int INDEX_BITS = 6;
  localparam int QDEPTH     = 4;
  localparam int INIT_STATE = 1;
  localparam int ENTRIES    = 1 << INDEX_BITS;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   pred_req;
  logic [PC_WIDTH-1:0]    pred_pc;
  logic                   pred_ready;
  logic                   pred_valid;
  logic                   pred_taken;
  logic                   res_valid;
  logic                   res_taken;
  logic                   flush;
  logic                   mispredict;
  logic                   res_err;
  logic [$clog2(QDEPTH):0] inflight;

  always #5 clk = ~clk;

  bht_predict_unit #(
    .PC_WIDTH   (PC_WIDTH),
    .INDEX_BITS (INDEX_BITS),
    .QDEPTH     (QDEPTH),
    .INIT_STATE (2'(INIT_STATE))
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pred_req   (pred_req),
    .pred_pc    (pred_pc),
    .pred_ready (pred_ready),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .flush      (flush),
    .mispredict (mispredict),
    .res_err    (res_err),
    .inflight   (inflight)
  );

  typedef struct {
    int idx;
    int ctr;
  } entry_t;

  entry_t q[$];
  int     tbl[ENTRIES];
  int     exp_pv;
  int     exp_pt;
  int     exp_mis;
  int     exp_err;
  int     n_cmp  = 0;
  int     n_fail = 0;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (tbl[i]) tbl[i] = INIT_STATE;
    q.delete();
    exp_pv  = 0;
    exp_pt  = 0;
    exp_mis = 0;
    exp_err = 0;
  endtask

  task automatic check_all();
    check_output("pred_valid", 32'(pred_valid), 32'(exp_pv));
    check_output("pred_taken", 32'(pred_taken), 32'(exp_pt));
    check_output("mispredict", 32'(mispredict), 32'(exp_mis));
    check_output("res_err",    32'(res_err),    32'(exp_err));
    check_output("inflight",   32'(inflight),   32'(q.size()));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    pred_req  = 1'b0;
    pred_pc   = '0;
    res_valid = 1'b0;
    res_taken = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_all();
    check_output("ready_after_reset", 32'(pred_ready), 32'd1);
  endtask

  // One clock of stimulus: the model decides what the DUT must show one cycle later.
  task automatic apply_stimulus(input bit req, input logic [31:0] pc, input bit rv,
                                input bit rt, input bit fl);
    int     idx;
    int     c;
    bit     acc;
    entry_t e;
    pred_req  = req;
    pred_pc   = pc;
    res_valid = rv;
    res_taken = rt;
    flush     = fl;
    check_output("pred_ready", 32'(pred_ready), 32'(q.size() < QDEPTH));
    check_output("inflight_pre", 32'(inflight), 32'(q.size()));

    acc = req && (q.size() < QDEPTH);
    idx = int'((pc >> 2) % ENTRIES);
    c   = tbl[idx];

    exp_mis = 0;
    exp_err = 0;
    if (rv) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_mis = ((e.ctr >= 2) != rt) ? 1 : 0;
        if (rt) tbl[e.idx] = (e.ctr < 3) ? e.ctr + 1 : 3;
        else    tbl[e.idx] = (e.ctr > 0) ? e.ctr - 1 : 0;
      end else begin
        exp_err = 1;
      end
    end
    if (acc) q.push_back('{idx: idx, ctr: c});
    if (fl) begin
      q.delete();
      exp_pv = 0;
    end else begin
      exp_pv = acc ? 1 : 0;
      if (acc) exp_pt = (c >= 2) ? 1 : 0;
    end

    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drain();
    while (q.size() > 0) apply_stimulus(1'b0, 32'h0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    pred_req  = 1'b0;
    pred_pc   = '0;
    res_valid = 1'b0;
    res_taken = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Basic lookup and saturation toward strongly taken
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    check_output("first_lookup_taken", 32'(pred_taken), 32'd0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check_output("first_resolve_mis", 32'(mispredict), 32'd1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    end
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    check_output("saturated_taken", 32'(pred_taken), 32'd1);
    drain();

    // Full queue: extra requests ignored, same-cycle pop does not admit
    for (int i = 0; i < QDEPTH; i++) apply_stimulus(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    check_output("full_inflight", 32'(inflight), 32'(QDEPTH));
    apply_stimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    check_output("full_no_valid", 32'(pred_valid), 32'd0);
    apply_stimulus(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    drain();

    // Read-before-write on the same index
    do_reset();
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
    check_output("rbw_stale_taken", 32'(pred_taken), 32'd0);
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    check_output("rbw_updated_taken", 32'(pred_taken), 32'd1);
    drain();

    // Flush combined with a resolve, then a resolve on the empty queue
    do_reset();
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 32'h40 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h80, 1'b1, 1'b1, 1'b1);
    check_output("flush_inflight", 32'(inflight), 32'd0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check_output("empty_res_err", 32'(res_err), 32'd1);
    apply_stimulus(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    drain();

    // Reset with entries outstanding
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'h48, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 32'h48, 1'b0, 1'b0, 1'b0);
    do_reset();
    apply_stimulus(1'b1, 32'h48, 1'b0, 1'b0, 1'b0);
    check_output("post_reset_init", 32'(pred_taken), 32'd0);

    // Random traffic over a small set of aliasing indices
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        pc = ($urandom & ~32'h0000_00FC) | (32'($urandom_range(0, 7)) << 2);
        apply_stimulus(1'($urandom_range(0, 99) < 60), pc,
                       1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 99) < 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
